fulladder_bist: RTL and testbench



---
 rtl/fulladder_bist.sv | 77 +++++++
 tb/tb_fulladder_bist.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fulladder_bist.sv
// fulladder_bist: exhaustive BIST controller for a full adder with MISR compaction and golden-signature compare
module fulladder_bist #(
  parameter logic [7:0] GOLDEN = 8'h47,
  parameter logic [7:0] SEED   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       cin,
  input  logic       s,
  input  logic       cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx, pat_nx;
  logic [7:0] sig_nx, misr;
  logic busy_nx, done_nx, pass_nx;
  // x^8+x^4+x^3+x^2+1 feedback; adder response folds into the two LSBs
  assign misr = {signature[6:0], 1'b0} ^ (signature[7] ? 8'h1D : 8'h00) ^ {6'b0, cout, s};
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pat_nx   = {a, b, cin};
    sig_nx   = signature;
    busy_nx  = busy;
    done_nx  = done;
    pass_nx  = pass;
    case (state)
      IDLE, DONE: if (start) begin
        state_nx = RUN;
        cnt_nx   = 3'd0;
        pat_nx   = 3'd0;
        sig_nx   = SEED;
        busy_nx  = 1'b1;
        done_nx  = 1'b0;
        pass_nx  = 1'b0;
      end
      RUN: begin
        sig_nx   = misr;
        cnt_nx   = (cnt == 3'd7) ? cnt : cnt + 3'd1;
        pat_nx   = (cnt == 3'd7) ? 3'd0 : cnt + 3'd1;
        state_nx = (cnt == 3'd7) ? CHECK : RUN;
      end
      CHECK: begin
        state_nx = DONE;
        pass_nx  = (signature == GOLDEN);
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      {a, b, cin} <= 3'd0;
      signature   <= SEED;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      {a, b, cin} <= pat_nx;
      signature   <= sig_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      pass        <= pass_nx;
    end
endmodule

// File: tb/tb_fulladder_bist.sv
// tb_fulladder_bist: directed checks of the full-adder BIST controller with a behavioural adder and injectable faults
module tb_fulladder_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic a, b, cin, s, cout, busy, done, pass;
  logic [7:0] signature;
  logic stuck_s0 = 1'b0;
  logic stuck_c1 = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign s    = stuck_s0 ? 1'b0 : a ^ b ^ cin;
  assign cout = stuck_c1 ? 1'b1 : (a & b) | (cin & (a ^ b));

  fulladder_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_run(input logic [7:0] exp_sig, input logic exp_pass, input string name);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL %s_check_state busy,done=%b%b expected 10", name, busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, pass, signature} !== {2'b01, exp_pass, exp_sig}) begin
      errors++;
      $display("FAIL %s_final busy=%b done=%b pass=%b sig=%h expected busy=0 done=1 pass=%b sig=%h",
               name, busy, done, pass, signature, exp_pass, exp_sig);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({a, b, cin, busy, done, pass, signature} !== 14'd0) begin
      errors++;
      $display("FAIL reset_values abc=%b%b%b busy=%b done=%b pass=%b sig=%h expected all zero", a, b, cin, busy, done, pass, signature);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({a, b, cin, busy, done, pass, signature} !== 14'd0) begin
        errors++;
        $display("FAIL idle_cycle_%0d abc=%b%b%b busy=%b done=%b pass=%b sig=%h expected all zero", i, a, b, cin, busy, done, pass, signature);
      end
    end
  endtask

  task automatic test_good_run();
    logic [7:0] exp_sig [8];
    logic [2:0] exp_pat;
    exp_sig = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h09, 8'h10, 8'h22, 8'h47};
    start_run();
    checks++;
    if ({a, b, cin, busy, done, signature} !== {3'd0, 2'b10, 8'h00}) begin
      errors++;
      $display("FAIL good_e0 abc=%b%b%b busy=%b done=%b sig=%h expected abc=000 busy=1 done=0 sig=00", a, b, cin, busy, done, signature);
    end
    for (int k = 1; k <= 8; k++) begin
      exp_pat = (k < 8) ? 3'(k) : 3'd0;
      @(posedge clk); #1;
      checks++;
      if ({a, b, cin, busy, signature} !== {exp_pat, 1'b1, exp_sig[k-1]}) begin
        errors++;
        $display("FAIL good_e%0d abc=%b%b%b busy=%b sig=%h expected abc=%b busy=1 sig=%h", k, a, b, cin, busy, signature, exp_pat, exp_sig[k-1]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, pass, signature} !== {3'b011, 8'h47}) begin
      errors++;
      $display("FAIL good_e9 busy=%b done=%b pass=%b sig=%h expected busy=0 done=1 pass=1 sig=47", busy, done, pass, signature);
    end
  endtask

  task automatic test_stuck_s0();
    stuck_s0 = 1'b1;
    start_run();
    finish_run(8'h2E, 1'b0, "stuck_s0");
  endtask

  task automatic test_rerun_from_done();
    stuck_s0 = 1'b0;
    start_run();
    checks++;
    if ({busy, done, pass, signature} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL rerun_clear busy=%b done=%b pass=%b sig=%h expected busy=1 done=0 pass=0 sig=00", busy, done, pass, signature);
    end
    finish_run(8'h47, 1'b1, "rerun");
  endtask

  task automatic test_stuck_c1();
    stuck_c1 = 1'b1;
    start_run();
    finish_run(8'h8A, 1'b0, "stuck_c1");
    stuck_c1 = 1'b0;
  endtask

  task automatic test_start_during_run();
    start_run();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL start_in_run_e8 busy,done=%b%b expected 10", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, pass, signature} !== {3'b011, 8'h47}) begin
      errors++;
      $display("FAIL start_in_run_e9 busy=%b done=%b pass=%b sig=%h expected busy=0 done=1 pass=1 sig=47", busy, done, pass, signature);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, pass, signature} !== {3'b011, 8'h47}) begin
        errors++;
        $display("FAIL b2b_run%0d_done busy=%b done=%b pass=%b sig=%h expected busy=0 done=1 pass=1 sig=47", r, busy, done, pass, signature);
      end
      @(posedge clk); #1;
      checks++;
      if ({busy, done, pass, signature} !== {3'b100, 8'h00}) begin
        errors++;
        $display("FAIL b2b_run%0d_restart busy=%b done=%b pass=%b sig=%h expected busy=1 done=0 pass=0 sig=00", r, busy, done, pass, signature);
      end
    end
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, signature} !== {3'b011, 8'h47}) begin
      errors++;
      $display("FAIL b2b_last busy=%b done=%b pass=%b sig=%h expected busy=0 done=1 pass=1 sig=47", busy, done, pass, signature);
    end
  endtask

  task automatic test_reset_midrun();
    start_run();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({busy, signature} !== {1'b1, 8'h04}) begin
      errors++;
      $display("FAIL midrun_e4 busy=%b sig=%h expected busy=1 sig=04", busy, signature);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a, b, cin, busy, done, pass, signature} !== 14'd0) begin
      errors++;
      $display("FAIL midrun_async abc=%b%b%b busy=%b done=%b pass=%b sig=%h expected all zero", a, b, cin, busy, done, pass, signature);
    end
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({a, b, cin, busy, done, pass, signature} !== 14'd0) begin
      errors++;
      $display("FAIL midrun_idle abc=%b%b%b busy=%b done=%b pass=%b sig=%h expected all zero", a, b, cin, busy, done, pass, signature);
    end
    start_run();
    finish_run(8'h47, 1'b1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_stuck_s0();
    test_rerun_from_done();
    test_stuck_c1();
    test_start_during_run();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
